conv_output_writer: RTL and testbench

//  Downstream stage of the convolution datapath. Takes wide signed accumulator

---
 rtl/conv_output_writer.sv | 156 +++++++++++++++
 tb/tb_conv_output_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_writer.sv
// Requantising output writer: accepts wide accumulator beats, writes 16-bit results to dom RAM.
// Latency: RAM write 1 cycle after handshake; done pulses 2 cycles after the final handshake.
// Backpressure: result_ready is high only in RUN; upstream stalls in IDLE/DRAIN/DONE.
//
// Ports:
//   clk, reset          single clock domain, synchronous active-high reset
//   start               one-cycle pulse that arms a new frame (honoured in IDLE only)
//   result_valid/ready  valid/ready handshake for accumulator beats
//   result_data/last    signed accumulator value, end-of-frame marker
//   dut__dom__*         output RAM port: address, data, enable, write
//   done                one-cycle pulse when the frame's final write has been issued
//   sat_count           clamp events in the current frame, sticks at 255
//
// Optional build macro: RELU_EN -- when defined, negative results (after
// saturation) are written as zero. Negative clamps are still counted.

module conv_output_writer #(
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              result_valid,
  output logic              result_ready,
  input  logic [ACC_W-1:0]  result_data,
  input  logic              result_last,
  output logic [ADDR_W-1:0] dut__dom__address,
  output logic [15:0]       dut__dom__data,
  output logic              dut__dom__enable,
  output logic              dut__dom__write,
  output logic              done,
  output logic [7:0]        sat_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-32768);
  localparam logic [ADDR_W-1:0]       LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic                ready_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         data_q;
  logic                done_q;
  logic [7:0]          sat_q;

  logic                hs;
  logic                frame_end;
  logic signed [ACC_W-1:0] shifted;
  logic [15:0]         proc_data;
  logic                proc_sat;

  // ready_q mirrors (state == RUN); it is kept as its own register so the
  // handshake never depends on state decode.
  assign hs        = result_valid & ready_q;
  assign frame_end = result_last | (wr_ptr == LAST_PTR);

  // Requantisation: sign-preserving shift, then clamp to the int16 range.
  always_comb begin
    shifted   = $signed(result_data) >>> SHIFT;
    proc_sat  = 1'b0;
    proc_data = shifted[15:0];
    if (shifted > SAT_MAX) begin
      proc_data = 16'h7FFF;
      proc_sat  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      proc_data = 16'h8000;
      proc_sat  = 1'b1;
    end
`ifdef RELU_EN
    // ReLU is applied after the clamp, so a negative clamp is still counted.
    if (proc_data[15]) begin
      proc_data = 16'h0000;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      sat_q   <= '0;
    end else begin
      // Strobes default low; address/data hold their last written value.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            ready_q <= 1'b1;
            wr_ptr  <= '0;
            sat_q   <= '0;
          end
        end
        RUN: begin
          if (hs) begin
            wr_en_q <= 1'b1;
            addr_q  <= wr_ptr;
            data_q  <= proc_data;
            if (proc_sat && (sat_q != 8'hFF)) begin
              sat_q <= sat_q + 8'd1;
            end
            if (frame_end) begin
              // Pointer is left at the final entry so it never wraps.
              state   <= DRAIN;
              ready_q <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The final write is on the RAM port during this cycle.
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // A write pending from the previous handshake is visible in the cycle a
  // reset is raised; masking the strobe with reset drops that write instead of
  // letting it land in the RAM.
  assign dut__dom__enable  = wr_en_q & ~reset;
  assign dut__dom__write   = wr_en_q & ~reset;
  assign dut__dom__address = addr_q;
  assign dut__dom__data    = data_q;
  assign result_ready      = ready_q;
  assign done              = done_q;
  assign sat_count         = sat_q;

endmodule

// File: tb/tb_conv_output_writer.sv
module tb_conv_output_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_data;
  logic        result_last;
  logic [2:0]  dut__dom__address;
  logic [15:0] dut__dom__data;
  logic        dut__dom__enable;
  logic        dut__dom__write;
  logic        done;
  logic [7:0]  sat_count;

  conv_output_writer #(.ACC_W(32), .SHIFT(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .result_valid      (result_valid),
    .result_ready      (result_ready),
    .result_data       (result_data),
    .result_last       (result_last),
    .dut__dom__address (dut__dom__address),
    .dut__dom__data    (dut__dom__data),
    .dut__dom__enable  (dut__dom__enable),
    .dut__dom__write   (dut__dom__write),
    .done              (done),
    .sat_count         (sat_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_done_cyc = -1;
  int done_seen    = 0;
  int exp_frames   = 0;
  logic [18:0] sb[$];          // {address, data}
  logic [31:0] frame_vals[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model(input logic [31:0] v, output bit sat);
    int s;
    logic [15:0] r;
    s   = $signed(v) >>> 8;
    sat = 1'b0;
    if (s > 32767) begin
      r = 16'h7FFF; sat = 1'b1;
    end else if (s < -32768) begin
      r = 16'h8000; sat = 1'b1;
    end else begin
      r = s[15:0];
    end
`ifdef RELU_EN
    if (r[15]) r = 16'h0000;
`endif
    return r;
  endfunction

  // Write / done monitor
  always @(negedge clk) begin
    if (dut__dom__enable) begin
      logic [18:0] e;
      check("wr_strobe", {31'd0, dut__dom__write}, 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_write_addr", {29'd0, dut__dom__address}, 32'hFFFFFFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", {29'd0, dut__dom__address}, {29'd0, e[18:16]});
        check("wr_data", {16'd0, dut__dom__data}, {16'd0, e[15:0]});
      end
    end
    if (done) begin
      check("done_cycle", cyc, exp_done_cyc);
      done_seen++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] v, input bit last, input int idx, inout int exp_sat);
    bit got, s;
    logic [15:0] d;
    logic [2:0]  a;
    result_data  = v;
    result_last  = last;
    result_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      check("hs_timeout", {31'd0, result_ready}, 32'd1);
      return;
    end
    d = model(v, s);
    if (s) exp_sat++;
    a = idx[2:0];
    sb.push_back({a, d});
    @(posedge clk); #1;
    if (last || idx == 7) exp_done_cyc = cyc + 1;
  endtask

  task automatic wait_done(input int exp_sat);
    for (int k = 0; k < 20; k++) begin
      if (done_seen == exp_frames) break;
      @(negedge clk);
    end
    check("done_count", done_seen, exp_frames);
    check("sb_drained", sb.size(), 0);
    check("sat_count", {24'd0, sat_count}, exp_sat);
  endtask

  task automatic run_frame(input int n, input bit last_at_end, input bit gaps, input bit poke_start);
    int exp_sat = 0;
    pulse_start();
    for (int i = 0; i < n; i++) begin
      if (poke_start && i == 2) begin
        result_valid = 1'b0;
        pulse_start();
      end
      send_beat(frame_vals[i], last_at_end && (i == n - 1), i, exp_sat);
      if (gaps && i != n - 1) begin
        result_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    // Valid is still high here; the writer must not accept past the frame end.
    @(negedge clk);
    check("ready_after_last", {31'd0, result_ready}, 32'd0);
    result_valid = 1'b0;
    result_last  = 1'b0;
    exp_frames++;
    wait_done(exp_sat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; result_valid = 1'b0;
    result_data = '0; result_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready",  {31'd0, result_ready}, 0);
    check("rst_enable", {31'd0, dut__dom__enable}, 0);
    check("rst_done",   {31'd0, done}, 0);
    check("rst_sat",    {24'd0, sat_count}, 0);
    check("rst_addr",   {29'd0, dut__dom__address}, 0);
    check("rst_data",   {16'd0, dut__dom__data}, 0);

    // Valid held in IDLE without start: no acceptance, no writes, no done.
    @(posedge clk); #1;
    result_valid = 1'b1; result_data = 32'h0000_1200; result_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, result_ready}, 0);
    end
    @(posedge clk); #1;
    result_valid = 1'b0; result_last = 1'b0;
    check("idle_no_done", done_seen, 0);

    // Frame 1: i<<8, last on beat 7.
    frame_vals = {};
    for (int i = 0; i < 8; i++) frame_vals.push_back(i << 8);
    run_frame(8, 1'b1, 1'b0, 1'b0);

    // Frame 2: clamps and a small negative, early last on 3rd beat.
    frame_vals = {32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FB00};
    run_frame(3, 1'b1, 1'b0, 1'b0);

    // Frame 3: exact int16 boundaries with gaps in valid, stray start mid-frame.
    frame_vals = {32'h007F_FF00, 32'h0080_0000, 32'hFF80_0000, 32'hFF7F_FF00};
    run_frame(4, 1'b1, 1'b1, 1'b1);

    // Frame 4: no last at all; the frame ends on entry DEPTH-1.
    frame_vals = {32'h0000_00FF, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) frame_vals.push_back($urandom);
    run_frame(8, 1'b0, 1'b0, 1'b0);

    // Reset raised the cycle after a handshake drops the pending write.
    begin
      int dummy_sat = 0;
      pulse_start();
      send_beat(32'h0000_0300, 1'b0, 0, dummy_sat);
      result_data = 32'h0000_0500; result_last = 1'b0; result_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (result_ready) break;
      end
      @(posedge clk); #1;
      reset = 1'b1; result_valid = 1'b0;
      @(negedge clk);
      check("rstmid_enable", {31'd0, dut__dom__enable}, 0);
      check("rstmid_write",  {31'd0, dut__dom__write}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_addr",  {29'd0, dut__dom__address}, 0);
      check("rstmid_data",  {16'd0, dut__dom__data}, 0);
      check("rstmid_ready", {31'd0, result_ready}, 0);
      check("rstmid_sat",   {24'd0, sat_count}, 0);
      check("rstmid_done",  {31'd0, done}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rstmid_no_done", done_seen, exp_frames);
      check("rstmid_sb", sb.size(), 0);
    end

    // After reset the next frame starts again at address 0.
    frame_vals = {32'h0000_0A00, 32'hFFFF_F600, 32'h0123_4567};
    run_frame(3, 1'b1, 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
